// File: rtl/umi_merger.sv
// Two-input UMI merger: fixed priority to port 0 with a starvation guard for port 1,
// followed by a one-entry registered output stage. Define UMI_MERGER_RR_EN for round-robin.
module umi_merger #(
  parameter int AW         = 64,
  parameter int UW         = 256,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          umi0_in_valid,
  input  logic [UW-1:0] umi0_in_packet,
  output logic          umi0_in_ready,
  input  logic          umi1_in_valid,
  input  logic [UW-1:0] umi1_in_packet,
  output logic          umi1_in_ready,
  output logic          umi_out_valid,
  output logic [UW-1:0] umi_out_packet,
  input  logic          umi_out_ready
);

  // Address width only keeps the parameter list aligned with the rest of the UMI fabric.
  localparam int unused_aw = AW;

  logic          r_out_valid;
  logic [UW-1:0] r_out_packet;
  logic          w_can_load;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_acc0;
  logic          w_acc1;

  assign w_can_load = ~r_out_valid | umi_out_ready;

`ifdef UMI_MERGER_RR_EN
  localparam int unused_starve_max = STARVE_MAX;

  // Index of the port granted last; starts at 1 so port 0 wins the first tie.
  logic r_last_grant;

  assign w_grant1 = umi1_in_valid & (~umi0_in_valid | ~r_last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_acc0) begin
      r_last_grant <= 1'b0;
    end else if (w_acc1) begin
      r_last_grant <= 1'b1;
    end
  end
`else
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] r_starve_cnt;
  logic       w_starved;

  assign w_starved = (STARVE_LIM != 8'd0) && (r_starve_cnt == STARVE_LIM);
  assign w_grant1  = umi1_in_valid & (~umi0_in_valid | w_starved);

  // Counts port-0 wins while port 1 is waiting; only moves on accepted transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 8'd0;
    end else if (w_acc0 | w_acc1) begin
      if (w_acc1 | ~umi1_in_valid) begin
        r_starve_cnt <= 8'd0;
      end else if (r_starve_cnt != STARVE_LIM) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end
`endif

  assign w_grant0 = umi0_in_valid & ~w_grant1;
  assign w_acc0   = w_grant0 & w_can_load & ~reset;
  assign w_acc1   = w_grant1 & w_can_load & ~reset;

  assign umi0_in_ready = w_acc0;
  assign umi1_in_ready = w_acc1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_packet <= '0;
    end else if (w_acc0 | w_acc1) begin
      r_out_valid  <= 1'b1;
      r_out_packet <= w_acc1 ? umi1_in_packet : umi0_in_packet;
    end else if (umi_out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign umi_out_valid  = r_out_valid;
  assign umi_out_packet = r_out_packet;

endmodule

// File: tb/tb_umi_merger.sv
// Self-checking bench for umi_merger: directed arbitration scenarios plus randomized
// traffic checked against a cycle model and an in-order packet scoreboard.
module tb_umi_merger;

  localparam int UW = 256;
  localparam int SM = 3;

  logic          clk;
  logic          reset;
  logic          v0, v1, r0, r1, ov, ordy;
  logic [UW-1:0] p0, p1, op;

  logic          sreset, sv0, sv1, sr0, sr1, sov;
  logic [UW-1:0] sp0, sp1, sop;

  int n_total;
  int n_bad;

  umi_merger #(.AW(64), .UW(UW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .umi0_in_valid(v0), .umi0_in_packet(p0), .umi0_in_ready(r0),
    .umi1_in_valid(v1), .umi1_in_packet(p1), .umi1_in_ready(r1),
    .umi_out_valid(ov), .umi_out_packet(op), .umi_out_ready(ordy)
  );

  umi_merger #(.AW(64), .UW(UW), .STARVE_MAX(0)) dut_strict (
    .clk(clk), .reset(sreset),
    .umi0_in_valid(sv0), .umi0_in_packet(sp0), .umi0_in_ready(sr0),
    .umi1_in_valid(sv1), .umi1_in_packet(sp1), .umi1_in_ready(sr1),
    .umi_out_valid(sov), .umi_out_packet(sop), .umi_out_ready(1'b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [UW-1:0] got, input logic [UW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state: output register contents, starvation count, last grant.
  logic          m_vld;
  logic [UW-1:0] m_pkt;
  int            m_cnt;
  logic          m_last;
  logic [UW-1:0] sb[$];
  logic [UW-1:0] q0[$];
  logic [UW-1:0] q1[$];
  logic          en0, en1;
  logic          a0, a1, gd0, gd1;

  task automatic feed();
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    v0 = (v0 && !a0) || (en0 && q0.size() != 0);
    v1 = (v1 && !a1) || (en1 && q1.size() != 0);
    p0 = (q0.size() != 0) ? q0[0] : '0;
    p1 = (q1.size() != 0) ? q1[0] : '0;
  endtask

  task automatic cyc();
    logic g1, cl, e0, e1;
    logic [UW-1:0] pkt;
    @(negedge clk);
`ifdef UMI_MERGER_RR_EN
    g1 = v1 && (!v0 || !m_last);
`else
    g1 = v1 && (!v0 || (SM != 0 && m_cnt == SM));
`endif
    cl = !m_vld || ordy;
    e1 = g1 && cl && !reset;
    e0 = v0 && !g1 && cl && !reset;
    chk("rdy0", r0, e0);
    chk("rdy1", r1, e1);
    chk("out_vld", ov, m_vld);
    chk("out_pkt", op, m_pkt);
    if (!reset && m_vld && ordy && sb.size() != 0) chk("sb_order", op, sb.pop_front());
    a0 = e0; a1 = e1; gd0 = r0; gd1 = r1;
    @(posedge clk);
    if (reset) begin
      m_vld = 1'b0; m_pkt = '0; m_cnt = 0; m_last = 1'b1;
      sb.delete();
    end else if (a0 || a1) begin
      pkt = a1 ? p1 : p0;
      m_vld = 1'b1;
      m_pkt = pkt;
      sb.push_back(pkt);
      if (a1 || !v1) m_cnt = 0;
      else if (m_cnt != SM) m_cnt++;
      m_last = a1;
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    #1;
    feed();
  endtask

  task automatic start_phase();
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0;
    q0.delete(); q1.delete();
    en0 = 1'b1; en1 = 1'b1; ordy = 1'b1;
    a0 = 1'b0; a1 = 1'b0;
    feed();
    cyc();
    reset = 1'b0;
  endtask

  function automatic logic [UW-1:0] rnd_pkt();
    logic [UW-1:0] x;
    for (int k = 0; k < UW / 32; k++) x[k*32 +: 32] = $urandom;
    return x;
  endfunction

  initial begin
    logic exp_g1;
    clk = 1'b0; n_total = 0; n_bad = 0;
    m_vld = 1'b0; m_pkt = '0; m_cnt = 0; m_last = 1'b1;
    a0 = 1'b0; a1 = 1'b0;
    sreset = 1'b1; sv0 = 1'b0; sv1 = 1'b0; sp0 = '0; sp1 = '0;

    // Reset held with both inputs valid: nothing may be accepted.
    reset = 1'b1; ordy = 1'b1; en0 = 1'b1; en1 = 1'b1;
    q0.push_back(256'hC0); q1.push_back(256'hD0);
    v0 = 1'b0; v1 = 1'b0;
    feed();
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_out_vld", ov, 1'b0);
    chk("rst_out_pkt", op, '0);
    reset = 1'b0;
    cyc();
    chk("first_grant", gd0, 1'b1);

    // Single back-to-back stream on port 0.
    start_phase();
    en1 = 1'b0;
    for (int i = 0; i < 10; i++) q0.push_back(UW'(8'hA0 + i));
    feed();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("stream_rdy", gd0, 1'b1);
    end
    for (int i = 0; i < 2; i++) cyc();

    // Both ports saturated: starvation guard / round-robin ordering.
    start_phase();
    for (int i = 0; i < 20; i++) begin
      q0.push_back(UW'(32'hE000 + i));
      q1.push_back(UW'(32'hF000 + i));
    end
    feed();
    for (int i = 0; i < 15; i++) begin
      cyc();
`ifdef UMI_MERGER_RR_EN
      exp_g1 = (i % 2) == 1;
`else
      exp_g1 = (i % 4) == 3;
`endif
      chk("arb_order", gd1, exp_g1);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    chk("post_rst_grant", gd0, 1'b1);

    // Backpressure, then reset while the output is stalled.
    start_phase();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(UW'(32'h1000 + i));
      q1.push_back(UW'(32'h2000 + i));
    end
    feed();
    cyc();
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_no_rdy", {gd0, gd1}, 2'b00);
    end
    ordy = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    ordy = 1'b0;
    for (int i = 0; i < 2; i++) cyc();
    reset = 1'b1;
    cyc();
    chk("stall_rst_vld", ov, 1'b0);
    reset = 1'b0;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) cyc();

    // Randomized traffic, backpressure and occasional resets.
    start_phase();
    for (int i = 0; i < 600; i++) begin
      en0 = $urandom_range(0, 3) != 0;
      en1 = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 99) == 0;
      while (q0.size() < 4) q0.push_back(rnd_pkt());
      while (q1.size() < 4) q1.push_back(rnd_pkt());
      cyc();
    end
    reset = 1'b0;

`ifndef UMI_MERGER_RR_EN
    // Strict priority instance: port 1 only gets through once port 0 goes idle.
    sv0 = 1'b1; sv1 = 1'b1; sp0 = 256'h300; sp1 = 256'h4D0;
    @(posedge clk); @(posedge clk); #1;
    sreset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("strict_r0", sr0, 1'b1);
      chk("strict_r1", sr1, 1'b0);
      @(posedge clk); #1;
      sp0 = sp0 + 1;
    end
    sv0 = 1'b0;
    @(negedge clk);
    chk("strict_p1_rdy", sr1, 1'b1);
    @(posedge clk); #1;
    sv1 = 1'b0;
    @(negedge clk);
    chk("strict_out_vld", sov, 1'b1);
    chk("strict_out_pkt", sop, 256'h4D0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
